iq_avg_bram_writer: RTL and testbench

- Fabric-side writer for a 1024x32 IQ-average snapshot BRAM; drives the BRAM's port A (write strobe, enable, address, write data).
- Accumulates 2^AVG_LOG2 consecutive valid I/Q sample pairs, then writes one packed averaged word per block to consecutive addresses from 0.
- Stops when the memory is full and raises done; the CPU reads the results through the BRAM's bus-side port.

---
 rtl/iq_avg_bram_writer.sv | 146 ++++++++++++++
 tb/tb_iq_avg_bram_writer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_avg_bram_writer.sv
// Fabric-side port-A writer for the IQ-average snapshot BRAM: it block-averages
// valid I/Q pairs and writes one packed {I_avg, Q_avg} word per block from address 0 up.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | after reset; waiting for arm, samples ignored
// ST_ACCUM | accumulating blocks and issuing one write per completed block
// ST_DONE  | last address written; samples ignored, done held until arm
module iq_avg_bram_writer #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic [DATA_W-1:0]     din_i,
    input  logic [DATA_W-1:0]     din_q,
    input  logic                  din_valid,
    output logic                  bram_we,
    output logic                  bram_en_a,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [2*DATA_W-1:0]   bram_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       words_written
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0]   acc_q_q, acc_q_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      we_q, we_d;
    logic [2*DATA_W-1:0]       wr_data_q, wr_data_d;
    logic [ADDR_W:0]           words_q, words_d;

    logic signed [ACC_W-1:0]   sample_i_ext, sample_q_ext;
    logic signed [ACC_W-1:0]   sum_i, sum_q;
    logic [DATA_W-1:0]         avg_i, avg_q;
    logic                      last_slot;
    logic                      accept;
    logic                      block_end;

    always_comb begin
        sample_i_ext = ACC_W'($signed(din_i));
        sample_q_ext = ACC_W'($signed(din_q));
        sum_i        = acc_i_q + sample_i_ext;
        sum_q        = acc_q_q + sample_q_ext;
        avg_i        = DATA_W'(sum_i >>> AVG_LOG2);
        avg_q        = DATA_W'(sum_q >>> AVG_LOG2);
        // The final address is being written now: nothing further may be scheduled.
        last_slot    = we_q && (addr_q == ADDR_LAST);
        accept       = (state_q == ST_ACCUM) && !arm && din_valid && !last_slot;
        block_end    = accept && (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d   = state_q;
        acc_i_d   = acc_i_q;
        acc_q_d   = acc_q_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        wr_data_d = wr_data_q;
        words_d   = words_q;

        if (we_q) begin
            addr_d  = addr_q + 1'b1;
            words_d = words_q + 1'b1;
        end

        if (accept) begin
            if (block_end) begin
                acc_i_d   = '0;
                acc_q_d   = '0;
                cnt_d     = '0;
                we_d      = 1'b1;
                wr_data_d = {avg_i, avg_q};
            end else begin
                acc_i_d = sum_i;
                acc_q_d = sum_q;
                cnt_d   = cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE:  if (arm) state_d = ST_ACCUM;
            ST_ACCUM: if (last_slot) state_d = ST_DONE;
            ST_DONE:  if (arm) state_d = ST_ACCUM;
            default:  state_d = ST_IDLE;
        endcase

        // Arm restarts from any state; a write already registered still goes out.
        if (arm) begin
            state_d = ST_ACCUM;
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
            addr_d  = '0;
            words_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_i_q   <= '0;
            acc_q_q   <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wr_data_q <= '0;
            words_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_i_q   <= acc_i_d;
            acc_q_q   <= acc_q_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wr_data_q <= wr_data_d;
            words_q   <= words_d;
        end
    end

    assign bram_we       = we_q;
    assign bram_en_a     = we_q;
    assign bram_addr     = addr_q;
    assign bram_wr_data  = wr_data_q;
    assign busy          = (state_q == ST_ACCUM);
    assign done          = (state_q == ST_DONE);
    assign words_written = words_q;

endmodule

// File: tb/tb_iq_avg_bram_writer.sv
// Directed bench for iq_avg_bram_writer: three instances (AVG_LOG2 = 4, 2, 0)
// share clock, reset and sample inputs but each has its own arm.
module tb_iq_avg_bram_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din_i = '0;
    logic [15:0] din_q = '0;
    logic        din_valid = 1'b0;
    logic        arm4 = 1'b0, arm2 = 1'b0, arm0 = 1'b0;

    logic        we4, en4, busy4, done4;
    logic [9:0]  addr4;
    logic [31:0] data4;
    logic [10:0] ww4;
    logic        we2, en2, busy2, done2;
    logic [9:0]  addr2;
    logic [31:0] data2;
    logic [10:0] ww2;
    logic        we0, en0, busy0, done0;
    logic [9:0]  addr0;
    logic [31:0] data0;
    logic [10:0] ww0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] tr_i [8] = '{16'd1, 16'd1, 16'd1, 16'd0, 16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFC};
    logic [15:0] tr_q [8] = '{16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd7, 16'd7, 16'd7, 16'd8};

    iq_avg_bram_writer #(.ADDR_W(10), .DATA_W(16), .AVG_LOG2(4)) u_avg4 (
        .clk(clk), .rst_n(rst_n), .arm(arm4), .din_i(din_i), .din_q(din_q),
        .din_valid(din_valid), .bram_we(we4), .bram_en_a(en4), .bram_addr(addr4),
        .bram_wr_data(data4), .busy(busy4), .done(done4), .words_written(ww4));

    iq_avg_bram_writer #(.ADDR_W(10), .DATA_W(16), .AVG_LOG2(2)) u_avg2 (
        .clk(clk), .rst_n(rst_n), .arm(arm2), .din_i(din_i), .din_q(din_q),
        .din_valid(din_valid), .bram_we(we2), .bram_en_a(en2), .bram_addr(addr2),
        .bram_wr_data(data2), .busy(busy2), .done(done2), .words_written(ww2));

    iq_avg_bram_writer #(.ADDR_W(10), .DATA_W(16), .AVG_LOG2(0)) u_avg0 (
        .clk(clk), .rst_n(rst_n), .arm(arm0), .din_i(din_i), .din_q(din_q),
        .din_valid(din_valid), .bram_we(we0), .bram_en_a(en0), .bram_addr(addr0),
        .bram_wr_data(data0), .busy(busy0), .done(done0), .words_written(ww0));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({we4, en4, addr4, data4, busy4, done4, ww4} !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_state: got we=%b addr=%0d data=%h busy=%b done=%b ww=%0d, expected all 0",
                     we4, addr4, data4, busy4, done4, ww4);
        end
        tick();
        rst_n = 1'b1;
        tick();
        arm4 = 1'b1;
        tick();
        arm4 = 1'b0;
        din_valid = 1'b1; din_i = 16'd100; din_q = 16'hFF9C;
        repeat (20) tick();
        n_checks++;
        if (busy4 !== 1'b1 || ww4 !== 11'd1) begin
            n_fail++;
            $display("FAIL reset_precond: got busy=%b ww=%0d, expected busy=1 ww=1", busy4, ww4);
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({we4, en4, addr4, data4, busy4, done4, ww4} !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_async: got we=%b addr=%0d data=%h busy=%b done=%b ww=%0d, expected all 0",
                     we4, addr4, data4, busy4, done4, ww4);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (we4 !== 1'b0 || busy4 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_arm cycle %0d: got we=%b busy=%b, expected 0 0", k, we4, busy4);
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_basic_average();
        arm4 = 1'b1;
        tick();
        arm4 = 1'b0;
        din_valid = 1'b1; din_i = 16'd100; din_q = 16'hFF9C;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k < 15) begin
                n_checks++;
                if (we4 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_early_we at valid %0d: got %b expected 0", k, we4);
                end
            end else begin
                n_checks++;
                if (we4 !== 1'b1 || en4 !== 1'b1 || addr4 !== 10'd0 || data4 !== 32'h0064FF9C || ww4 !== 11'd0) begin
                    n_fail++;
                    $display("FAIL basic_write: got we=%b en=%b addr=%0d data=%h ww=%0d, expected 1 1 0 0064ff9c 0",
                             we4, en4, addr4, data4, ww4);
                end
            end
        end
        din_valid = 1'b0;
        tick();
        n_checks++;
        if (we4 !== 1'b0 || en4 !== 1'b0 || ww4 !== 11'd1) begin
            n_fail++;
            $display("FAIL basic_after: got we=%b en=%b ww=%0d, expected 0 0 1", we4, en4, ww4);
        end
    endtask

    task automatic test_truncation();
        arm2 = 1'b1;
        tick();
        arm2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            din_valid = 1'b1; din_i = tr_i[k]; din_q = tr_q[k];
            tick();
            n_checks++;
            if (we2 !== (k == 3 || k == 7) || en2 !== we2 || busy2 !== 1'b1 || done2 !== 1'b0) begin
                n_fail++;
                $display("FAIL trunc_strobe at sample %0d: got we=%b en=%b busy=%b done=%b", k, we2, en2, busy2, done2);
            end
            if (k == 3) begin
                n_checks++;
                if (addr2 !== 10'd0 || data2 !== 32'h0000FFFF) begin
                    n_fail++;
                    $display("FAIL trunc_block0: got addr=%0d data=%h, expected 0 0000ffff", addr2, data2);
                end
            end
            if (k == 7) begin
                n_checks++;
                if (addr2 !== 10'd1 || data2 !== 32'hFFFC0007) begin
                    n_fail++;
                    $display("FAIL trunc_block1: got addr=%0d data=%h, expected 1 fffc0007", addr2, data2);
                end
            end
        end
        din_valid = 1'b0;
        tick();
        n_checks++;
        if (ww2 !== 11'd2) begin
            n_fail++;
            $display("FAIL trunc_words: got %0d expected 2", ww2);
        end
    endtask

    task automatic test_gapped();
        int n;
        logic exp_we;
        logic [31:0] exp_data;
        arm4 = 1'b1;
        din_valid = 1'b1; din_i = 16'h7FFF; din_q = 16'h7FFF;
        tick();
        arm4 = 1'b0;
        din_valid = 1'b0;
        n_checks++;
        if (ww4 !== 11'd0 || addr4 !== 10'd0 || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_rearm: got ww=%0d addr=%0d busy=%b, expected 0 0 1", ww4, addr4, busy4);
        end
        n = 0;
        for (int cyc = 0; cyc < 48 * 3; cyc++) begin
            if (cyc % 3 == 0) begin
                din_valid = 1'b1; din_i = 16'(n); din_q = 16'(-n);
                n++;
            end else begin
                din_valid = 1'b0;
            end
            tick();
            exp_we = (cyc % 3 == 0) && (n % 16 == 0);
            n_checks++;
            if (we4 !== exp_we) begin
                n_fail++;
                $display("FAIL gap_strobe cycle %0d: got %b expected %b", cyc, we4, exp_we);
            end
            if (exp_we) begin
                exp_data = {16'(16 * (n / 16 - 1) + 7), 16'(-16 * (n / 16 - 1) - 8)};
                n_checks++;
                if (addr4 !== 10'(n / 16 - 1) || data4 !== exp_data) begin
                    n_fail++;
                    $display("FAIL gap_write %0d: got addr=%0d data=%h, expected %0d %h",
                             n / 16 - 1, addr4, data4, n / 16 - 1, exp_data);
                end
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_fill_wrap();
        arm0 = 1'b1;
        tick();
        arm0 = 1'b0;
        for (int n = 0; n < 1030; n++) begin
            din_valid = 1'b1; din_i = 16'(n); din_q = ~16'(n);
            tick();
            if (n < 1024) begin
                n_checks++;
                if (we0 !== 1'b1 || en0 !== 1'b1 || addr0 !== 10'(n) ||
                    data0 !== {16'(n), ~16'(n)} || ww0 !== 11'(n)) begin
                    n_fail++;
                    $display("FAIL fill_write %0d: got we=%b addr=%0d data=%h ww=%0d", n, we0, addr0, data0, ww0);
                end
            end else begin
                n_checks++;
                if (we0 !== 1'b0 || en0 !== 1'b0 || done0 !== 1'b1 || busy0 !== 1'b0 || ww0 !== 11'd1024) begin
                    n_fail++;
                    $display("FAIL fill_after %0d: got we=%b done=%b busy=%b ww=%0d, expected 0 1 0 1024",
                             n, we0, done0, busy0, ww0);
                end
                if (n == 1024) begin
                    n_checks++;
                    if (addr0 !== 10'd0) begin
                        n_fail++;
                        $display("FAIL fill_addr_wrap: got %0d expected 0", addr0);
                    end
                end
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_rearm();
        arm0 = 1'b1;
        din_valid = 1'b1; din_i = 16'h1234; din_q = 16'h5678;
        tick();
        arm0 = 1'b0;
        din_valid = 1'b0;
        n_checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || ww0 !== 11'd0 || addr0 !== 10'd0 || we0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_done: got done=%b busy=%b ww=%0d addr=%0d we=%b, expected 0 1 0 0 0",
                     done0, busy0, ww0, addr0, we0);
        end
        for (int k = 0; k < 5; k++) begin
            din_valid = 1'b1; din_i = 16'(k + 10); din_q = 16'(k + 20);
            tick();
            n_checks++;
            if (we0 !== 1'b1 || addr0 !== 10'(k) || data0 !== {16'(k + 10), 16'(k + 20)}) begin
                n_fail++;
                $display("FAIL rearm_prewrite %0d: got we=%b addr=%0d data=%h", k, we0, addr0, data0);
            end
        end
        arm0 = 1'b1;
        din_valid = 1'b1; din_i = 16'h1111; din_q = 16'h2222;
        tick();
        arm0 = 1'b0;
        n_checks++;
        if (we0 !== 1'b0 || ww0 !== 11'd0 || addr0 !== 10'd0 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm_accum: got we=%b ww=%0d addr=%0d busy=%b, expected 0 0 0 1", we0, ww0, addr0, busy0);
        end
        din_valid = 1'b1; din_i = 16'h0055; din_q = 16'h00AA;
        tick();
        din_valid = 1'b0;
        n_checks++;
        if (we0 !== 1'b1 || addr0 !== 10'd0 || data0 !== 32'h005500AA) begin
            n_fail++;
            $display("FAIL rearm_first_write: got we=%b addr=%0d data=%h, expected 1 0 005500aa", we0, addr0, data0);
        end
        tick();
        n_checks++;
        if (we0 !== 1'b0 || ww0 !== 11'd1) begin
            n_fail++;
            $display("FAIL rearm_words: got we=%b ww=%0d, expected 0 1", we0, ww0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_average();
        test_truncation();
        test_gapped();
        test_fill_wrap();
        test_rearm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
